// File: rtl/bm_rd.sv
// Bitmap byte reader: bursts bm_req for pack_len*4 cycles and repacks bm_q MSB-first into 32-bit words.
// First word RD_LAT+5 cycles after the accepted start; no backpressure, pack_start is dropped while busy.
module bm_rd #(
   parameter int LEN_W  = 13,
   parameter int RD_LAT = 2
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             pack_start,
   input  logic [LEN_W-1:0] pack_len,
   output logic             bm_req,
   input  logic [7:0]       bm_q,
   output logic [31:0]      pk_data,
   output logic             pk_vld,
   output logic             pk_sop,
   output logic             pk_eop,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

   state_t            state;
   logic [LEN_W+1:0]  byte_cnt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  word_cnt;
   logic [1:0]        lane;
   logic [23:0]       acc;
   logic [RD_LAT-1:0] req_pipe;
   logic              byte_vld;
   logic              accept;

   assign byte_vld = req_pipe[RD_LAT-1];
   // busy stays high through the done cycle, so a start there is dropped
   assign accept   = (state == IDLE) && !busy && pack_start;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         byte_cnt <= '0;
         len_q    <= '0;
         bm_req   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (busy) begin
                  busy <= 1'b0;
               end
               if (accept) begin
                  busy  <= 1'b1;
                  len_q <= pack_len;
                  if (pack_len != '0) begin
                     byte_cnt <= {pack_len, 2'b00};
                     bm_req   <= 1'b1;
                     state    <= REQ;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            REQ: begin
               // the buffer rewinds when bm_req falls, so it only drops after the last byte
               byte_cnt <= byte_cnt - (LEN_W+2)'(1);
               if (byte_cnt == (LEN_W+2)'(1)) begin
                  bm_req <= 1'b0;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               if (req_pipe == '0 && lane == 2'd0) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   generate
      if (RD_LAT == 1) begin : g_pipe1
         always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
               req_pipe <= '0;
            end else begin
               req_pipe <= bm_req;
            end
         end
      end else begin : g_pipen
         always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
               req_pipe <= '0;
            end else begin
               req_pipe <= {req_pipe[RD_LAT-2:0], bm_req};
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         lane     <= 2'd0;
         word_cnt <= '0;
         acc      <= '0;
         pk_data  <= '0;
         pk_vld   <= 1'b0;
         pk_sop   <= 1'b0;
         pk_eop   <= 1'b0;
      end else begin
         pk_vld <= 1'b0;
         pk_sop <= 1'b0;
         pk_eop <= 1'b0;
         if (accept) begin
            lane     <= 2'd0;
            word_cnt <= '0;
         end else if (byte_vld) begin
            lane <= lane + 2'd1;
            case (lane)
               2'd0: acc[23:16] <= bm_q;
               2'd1: acc[15:8]  <= bm_q;
               2'd2: acc[7:0]   <= bm_q;
               2'd3: begin
                  pk_data  <= {acc, bm_q};
                  pk_vld   <= 1'b1;
                  pk_sop   <= (word_cnt == '0);
                  pk_eop   <= (word_cnt == len_q - LEN_W'(1));
                  word_cnt <= word_cnt + LEN_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bm_rd.sv
// Bench for bm_rd: three instances (RD_LAT 2, 1, 4) share stimulus and are checked every cycle
// against a timeline model derived from accept cycle, burst length and read latency.
module tb_bm_rd;
   localparam int LEN_W = 13;
   localparam int NI    = 3;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic             rst_n;
   logic             pack_start;
   logic [LEN_W-1:0] pack_len;
   logic             bm_req_a  [NI];
   logic [7:0]       bm_q_a    [NI];
   logic [31:0]      pk_data_a [NI];
   logic             pk_vld_a  [NI];
   logic             pk_sop_a  [NI];
   logic             pk_eop_a  [NI];
   logic             busy_a    [NI];
   logic             done_a    [NI];

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         bm_rd #(
            .LEN_W  (LEN_W),
            .RD_LAT ((g == 0) ? 2 : ((g == 1) ? 1 : 4))
         ) u_dut (
            .clk_sys    (clk_sys),
            .rst_n      (rst_n),
            .pack_start (pack_start),
            .pack_len   (pack_len),
            .bm_req     (bm_req_a[g]),
            .bm_q       (bm_q_a[g]),
            .pk_data    (pk_data_a[g]),
            .pk_vld     (pk_vld_a[g]),
            .pk_sop     (pk_sop_a[g]),
            .pk_eop     (pk_eop_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g])
         );
      end
   endgenerate

   // buffer contents for the current burst, and the per-instance expectation model
   logic [7:0]  stream [256];
   logic [7:0]  dl     [NI][5];
   int          ptr    [NI];
   bit          m_act  [NI];
   int          m_t    [NI];
   int          m_len  [NI];
   int          nwords [NI];
   int          nreq   [NI];
   int          ndone  [NI];
   logic [31:0] sopw   [NI];
   int          cyc;
   int          errs;
   int          checks;

   typedef struct {
      int          len;
      logic [7:0]  base;
      logic [7:0]  step;
      int          gap;
      int          exp_words;
      int          exp_req;
      logic [31:0] exp_first;
   } vec_t;

   function automatic int lat_of(int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
   endfunction

   function automatic bit exp_busy(int i, int c);
      int d;
      int last;
      d    = c - m_t[i];
      last = (m_len[i] == 0) ? 2 : 4 * m_len[i] + lat_of(i) + 3;
      return m_act[i] && d >= 1 && d <= last;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic tick();
      logic [5:0]  ectl;
      logic [5:0]  gctl;
      logic [31:0] ew;
      logic [7:0]  b;
      int          d;
      int          k;
      int          len;
      int          lat;
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_act[i] = 1'b0;
         end else if (pack_start && !exp_busy(i, cyc)) begin
            m_act[i] = 1'b1;
            m_t[i]   = cyc;
            m_len[i] = int'(pack_len);
         end
      end
      @(negedge clk_sys);
      cyc++;
      for (int i = 0; i < NI; i++) begin
         lat = lat_of(i);
         b = bm_req_a[i] ? stream[ptr[i] & 255] : 8'hEE;
         ptr[i] = bm_req_a[i] ? ptr[i] + 1 : 0;
         for (int j = lat; j > 0; j--) dl[i][j] = dl[i][j-1];
         dl[i][0]  = b;
         bm_q_a[i] = dl[i][lat];

         ectl = '0;
         ew   = '0;
         if (rst_n && m_act[i]) begin
            d   = cyc - m_t[i];
            len = m_len[i];
            if (len == 0) begin
               ectl[1] = (d >= 1 && d <= 2);
               ectl[0] = (d == 2);
            end else begin
               ectl[5] = (d >= 1 && d <= 4 * len);
               k = d - lat - 5;
               if (k >= 0 && k % 4 == 0 && k / 4 < len) begin
                  ectl[4] = 1'b1;
                  ectl[3] = (k == 0);
                  ectl[2] = (k / 4 == len - 1);
                  ew = {stream[k], stream[k+1], stream[k+2], stream[k+3]};
               end
               ectl[1] = (d >= 1 && d <= 4 * len + lat + 3);
               ectl[0] = (d == 4 * len + lat + 3);
            end
         end
         gctl = {bm_req_a[i], pk_vld_a[i], pk_sop_a[i], pk_eop_a[i], busy_a[i], done_a[i]};
         check($sformatf("cyc%0d lat%0d req/vld/sop/eop/busy/done", cyc, lat), 32'(gctl), 32'(ectl));
         if (ectl[4]) check($sformatf("cyc%0d lat%0d pk_data", cyc, lat), pk_data_a[i], ew);

         if (pk_vld_a[i]) nwords[i]++;
         if (pk_vld_a[i] && pk_sop_a[i]) sopw[i] = pk_data_a[i];
         if (bm_req_a[i]) nreq[i]++;
         if (done_a[i]) ndone[i]++;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      tick();
      while (busy_a[0] || busy_a[1] || busy_a[2] ||
             exp_busy(0, cyc) || exp_busy(1, cyc) || exp_busy(2, cyc)) begin
         tick();
         n++;
         if (n > 400) begin
            checks++;
            errs++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
            break;
         end
      end
   endtask

   task automatic run_burst(int len, int gap);
      repeat (gap) tick();
      pack_len   = LEN_W'(len);
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      wait_idle();
   endtask

   task automatic fill_ramp(logic [7:0] base, logic [7:0] step);
      for (int k = 0; k < 256; k++) stream[k] = base + step * 8'(k);
   endtask

   initial begin : main
      vec_t vt [6];
      int   w0 [NI];
      int   r0 [NI];
      int   d0 [NI];
      int   n;
      int   len;

      vt[0] = '{1, 8'h11, 8'h11, 2, 1,  4, 32'h11223344};
      vt[1] = '{3, 8'h00, 8'h01, 1, 3, 12, 32'h00010203};
      vt[2] = '{0, 8'h00, 8'h01, 1, 0,  0, 32'h00000000};
      vt[3] = '{2, 8'hA0, 8'h01, 0, 2,  8, 32'hA0A1A2A3};
      vt[4] = '{5, 8'hF0, 8'h03, 0, 5, 20, 32'hF0F3F6F9};
      vt[5] = '{4, 8'h80, 8'h10, 3, 4, 16, 32'h8090A0B0};

      errs = 0;
      checks = 0;
      cyc = 0;
      pack_start = 1'b0;
      pack_len = '0;
      for (int i = 0; i < NI; i++) begin
         bm_q_a[i] = 8'h00;
         ptr[i] = 0;
         m_act[i] = 1'b0;
         m_t[i] = 0;
         m_len[i] = 0;
         nwords[i] = 0;
         nreq[i] = 0;
         ndone[i] = 0;
         sopw[i] = '0;
         for (int j = 0; j < 5; j++) dl[i][j] = 8'h00;
      end
      fill_ramp(8'h00, 8'h01);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // reset in the middle of the request burst
      pack_len = 4;
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("async reset lat%0d ctrl", lat_of(i)),
               32'({bm_req_a[i], pk_vld_a[i], pk_sop_a[i], pk_eop_a[i], busy_a[i], done_a[i]}), 32'h0);
         check($sformatf("async reset lat%0d pk_data", lat_of(i)), pk_data_a[i], 32'h0);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      fill_ramp(8'h40, 8'h01);
      for (int i = 0; i < NI; i++) w0[i] = nwords[i];
      run_burst(4, 1);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("post-reset lat%0d words", lat_of(i)), 32'(nwords[i] - w0[i]), 32'd4);
         check($sformatf("post-reset lat%0d first", lat_of(i)), sopw[i], 32'h40414243);
      end

      // table of single bursts, back-to-back where gap is 0
      for (int v = 0; v < 6; v++) begin
         fill_ramp(vt[v].base, vt[v].step);
         for (int i = 0; i < NI; i++) begin
            w0[i] = nwords[i];
            r0[i] = nreq[i];
            d0[i] = ndone[i];
         end
         run_burst(vt[v].len, vt[v].gap);
         for (int i = 0; i < NI; i++) begin
            check($sformatf("vec%0d lat%0d words", v, lat_of(i)), 32'(nwords[i] - w0[i]), 32'(vt[v].exp_words));
            check($sformatf("vec%0d lat%0d req cycles", v, lat_of(i)), 32'(nreq[i] - r0[i]), 32'(vt[v].exp_req));
            check($sformatf("vec%0d lat%0d done pulses", v, lat_of(i)), 32'(ndone[i] - d0[i]), 32'd1);
            if (vt[v].exp_words > 0)
               check($sformatf("vec%0d lat%0d first word", v, lat_of(i)), sopw[i], vt[v].exp_first);
         end
      end

      // second start during REQ with another length is dropped
      fill_ramp(8'h00, 8'h01);
      for (int i = 0; i < NI; i++) begin
         w0[i] = nwords[i];
         d0[i] = ndone[i];
      end
      pack_len = 3;
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      repeat (3) tick();
      pack_len = 6;
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      wait_idle();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("mid-burst start lat%0d words", lat_of(i)), 32'(nwords[i] - w0[i]), 32'd3);
         check($sformatf("mid-burst start lat%0d done pulses", lat_of(i)), 32'(ndone[i] - d0[i]), 32'd1);
      end

      // start coinciding with the RD_LAT=2 done pulse
      for (int i = 0; i < NI; i++) d0[i] = ndone[i];
      pack_len = 1;
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      n = 0;
      while (!done_a[0] && n < 100) begin
         tick();
         n++;
      end
      if (!done_a[0]) begin
         checks++;
         errs++;
         $display("FAIL done wait: done never seen, required within 100 cycles");
      end
      pack_len = 0;
      pack_start = 1'b1;
      tick();
      pack_start = 1'b0;
      wait_idle();
      check("start-at-done lat2 done pulses", 32'(ndone[0] - d0[0]), 32'd1);
      check("start-at-done lat1 done pulses", 32'(ndone[1] - d0[1]), 32'd2);
      check("start-at-done lat4 done pulses", 32'(ndone[2] - d0[2]), 32'd1);

      // random bursts with random data and occasional stray starts
      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < 64; k++) stream[k] = 8'($urandom);
         len = int'($urandom_range(0, 6));
         repeat ($urandom_range(0, 3)) tick();
         pack_len = LEN_W'(len);
         pack_start = 1'b1;
         tick();
         pack_start = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 10)) tick();
            pack_len = LEN_W'($urandom_range(0, 7));
            pack_start = 1'b1;
            tick();
            pack_start = 1'b0;
         end
         wait_idle();
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/bm_rd.md
Name: bm_rd

Overview:
- Reader/requester on the byte side of the bitmap buffer.
- On a start pulse it holds bm_req high for a contiguous burst of pack_len*4 cycles and captures the returned byte stream on bm_q.
- It repacks the bytes, MSB-first, into 32-bit words with valid, start-of-packet and end-of-packet markers, and hands them to the pack_top packet assembler.
- It is the counterpart of the writer that splits 32-bit words into bytes.

Parameters:
- LEN_W, 13: width of pack_len, in words. 13 bits covers up to 8191 words (32 KB).
- RD_LAT, 2: cycles from a cycle with bm_req=1 to the matching byte on bm_q. Legal values are 1 to 4.

Ports:
- clk_sys  in  1  system clock; all logic runs on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pack_start  in  1  one-cycle start pulse; ignored while busy=1.
- pack_len  in  LEN_W  number of 32-bit words to read; sampled in the cycle pack_start is accepted.
- bm_req  out  1  byte request to the buffer; held high contiguously for the whole burst.
- bm_q  in  8  byte returned by the buffer, RD_LAT cycles after the request.
- pk_data  out  32  packed word; the first byte of each group lands in [31:24].
- pk_vld  out  1  one-cycle strobe; pk_data is valid in that cycle.
- pk_sop  out  1  high together with pk_vld on the first word of a burst.
- pk_eop  out  1  high together with pk_vld on the last word of a burst.
- busy  out  1  high from the accept cycle until the done cycle, inclusive.
- done  out  1  one-cycle pulse when the burst is complete.

Behaviour:
- Reset, asynchronous on rst_n=0: every output is 0, the FSM is in IDLE, and all counters and pipeline registers are 0.
- Reset mid-burst aborts immediately. bm_req drops and no further pk_vld or done is issued.
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - pack_start=1 and pack_len!=0: latch byte_cnt=pack_len*4, width LEN_W+2. Go to REQ; busy=1 from the next cycle.
  - pack_start=1 and pack_len=0: go to DONE directly. No bm_req and no pk_vld; done pulses one cycle later.
- REQ:
  - bm_req=1 every cycle; byte_cnt decrements by one per cycle.
  - Leave for DRAIN in the cycle byte_cnt reaches 1 (that is the last request cycle).
  - bm_req never drops mid-burst, because the buffer rewinds its read pointer when the request goes low.
- Request-tracking pipeline: an RD_LAT-deep shift register of bm_req. Its tail, byte_vld, qualifies bm_q.
- DRAIN: bm_req=0. Wait until the pipeline is empty and the final word has been emitted, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy is cleared in the cycle after DONE.
- Packing:
  - A 2-bit lane counter advances on each byte_vld.
  - Lane 0 writes bm_q into [31:24], lane 1 into [23:16], lane 2 into [15:8], lane 3 into [7:0].
- Word output: on the byte_vld with lane=3, pk_data and pk_vld=1 are registered and appear the next cycle. pk_vld is 0 otherwise.
- pk_sop: 1 on the first word of the burst.
- pk_eop: 1 on word pack_len. With pack_len=1, sop and eop are both high on the same word.
- Latency:
  - First request at cycle t+1 after a pack_start accepted at t.
  - First pk_vld at t+1+3+RD_LAT+1.
  - Last pk_vld at t+pack_len*4+RD_LAT+1.
  - done two cycles after the last pk_vld.
- The lane counter and word counter reset to 0 at every accepted start.
- The byte counter is LEN_W+2 bits wide so it never wraps; the maximum pack_len gives 4*(2^LEN_W-1) bytes.
- pack_start while busy=1 is dropped. It is not queued and pack_len is not resampled.
- pack_start in the same cycle as done is also dropped, because busy is still 1.

Test Plan:
- Reset with rst_n=0 mid-REQ at pack_len=4 -> all outputs are 0 the same cycle; a later pack_start runs a clean burst with sop on the first word.
- pack_len=1, bm_q returning 0x11, 0x22, 0x33, 0x44, RD_LAT=2 -> exactly one pk_vld with pk_data=0x11223344, pk_sop=pk_eop=1; bm_req high exactly 4 cycles; done follows 2 cycles later.
- pack_len=3, bm_q as an incrementing byte stream from 0x00 -> words 0x00010203, 0x04050607, 0x08090A0B; sop only on the first word, eop only on the third; bm_req high exactly 12 contiguous cycles.
- pack_len=0 -> no bm_req and no pk_vld; busy high for 2 cycles; one done pulse.
- Second pack_start pulsed during REQ with a different pack_len -> ignored; word count matches the first pack_len and done pulses exactly once.
- Back-to-back bursts (pack_start the cycle after busy falls, pack_len=2 then 5) -> 2 then 5 words, lane alignment restarts at [31:24]; repeat with RD_LAT=1 and RD_LAT=4 to confirm the timing shifts.
